// File: rtl/dda_pkg.sv
// Shared types and helpers for the Lorenz DDA: phase encoding, FSM states and
// saturating add/sub that clamp a wide intermediate to an n-bit signed range.
package dda_pkg;

  localparam logic [2:0] PH_SIGMA  = 3'd0;
  localparam logic [2:0] PH_XRZ    = 3'd1;
  localparam logic [2:0] PH_XY     = 3'd2;
  localparam logic [2:0] PH_BZ     = 3'd3;
  localparam logic [2:0] PH_DX     = 3'd4;
  localparam logic [2:0] PH_DY     = 3'd5;
  localparam logic [2:0] PH_COMMIT = 3'd6;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam int MAXW = 64;
  typedef logic signed [MAXW-1:0] wide_t;

  function automatic wide_t sat_clamp(input wide_t v, input int n, output logic ovf);
    wide_t hi, lo, r;
    hi  = (wide_t'(1) <<< (n - 1)) - wide_t'(1);
    lo  = -hi - wide_t'(1);
    ovf = 1'b0;
    r   = v;
    if (v > hi) begin
      r   = hi;
      ovf = 1'b1;
    end else if (v < lo) begin
      r   = lo;
      ovf = 1'b1;
    end
    return r;
  endfunction

  function automatic wide_t sat_add(input wide_t a, input wide_t b, input int n, output logic ovf);
    return sat_clamp(a + b, n, ovf);
  endfunction

  function automatic wide_t sat_sub(input wide_t a, input wide_t b, input int n, output logic ovf);
    return sat_clamp(a - b, n, ovf);
  endfunction

endpackage

// File: rtl/dda_fxmul.sv
// Signed fixed-point multiply: full product, floor shift by FRAC, clamp to N bits.
// Combinational, no latency; ovf flags a clamp.
module dda_fxmul #(
  parameter int N    = 24,
  parameter int FRAC = 16
) (
  input  logic signed [N-1:0] a,
  input  logic signed [N-1:0] b,
  output logic signed [N-1:0] p,
  output logic                ovf
);

  logic signed [2*N-1:0] sh;

  assign sh  = ($signed({{N{a[N-1]}}, a}) * $signed({{N{b[N-1]}}, b})) >>> FRAC;
  // in range only when every bit from N-1 upward is a copy of the sign
  assign ovf = ~((&sh[2*N-1:N-1]) | ~(|sh[2*N-1:N-1]));
  assign p   = ovf ? (sh[2*N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}})
                   : sh[N-1:0];

endmodule

// File: rtl/dda_lorenz_seq.sv
// Time-multiplexed Lorenz Euler integrator sharing one multiplier over 7 phases.
// One step per 7 enabled cycles; en low stalls all state, start ignored while busy.
module dda_lorenz_seq
  import dda_pkg::*;
#(
  parameter int N    = 24,
  parameter int FRAC = 16,
  parameter int SW   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                start,
  input  logic [SW-1:0]       steps,
  input  logic signed [N-1:0] icx,
  input  logic signed [N-1:0] icy,
  input  logic signed [N-1:0] icz,
  input  logic signed [N-1:0] sigma,
  input  logic signed [N-1:0] beta,
  input  logic signed [N-1:0] rho,
  input  logic signed [N-1:0] dt,
  output logic signed [N-1:0] x,
  output logic signed [N-1:0] y,
  output logic signed [N-1:0] z,
  output logic                valid,
  output logic                done,
  output logic                busy,
  output logic                sat
);

  state_t              state;
  logic [2:0]          phase;
  logic [SW-1:0]       remain;
  logic signed [N-1:0] sig_r, bet_r, rho_r, dt_r;
  logic signed [N-1:0] p0, p1, p2, p3, p4, p5;

  logic signed [N-1:0] sa, sb, diff, ma, mb, prod, nx, ny, nz;
  logic                sub_ovf, sub_used, mul_ovf, ox, oy, oz;

  dda_fxmul #(.N(N), .FRAC(FRAC)) u_mul (.a(ma), .b(mb), .p(prod), .ovf(mul_ovf));

  always_comb begin
    sa       = y;
    sb       = x;
    sub_used = 1'b1;
    ma       = sig_r;
    mb       = diff;
    case (phase)
      PH_XRZ:    begin sa = rho_r; sb = z; ma = x; end
      PH_XY:     begin sub_used = 1'b0; ma = x; mb = y; end
      PH_BZ:     begin sub_used = 1'b0; ma = bet_r; mb = z; end
      PH_DX:     begin sub_used = 1'b0; ma = dt_r; mb = p0; end
      PH_DY:     begin sa = p1; sb = y; ma = dt_r; end
      PH_COMMIT: begin sa = p2; sb = p3; ma = dt_r; end
      default:   ;
    endcase
    diff = N'(sat_sub(wide_t'(sa), wide_t'(sb), N, sub_ovf));
    nx   = N'(sat_add(wide_t'(x), wide_t'(p4), N, ox));
    ny   = N'(sat_add(wide_t'(y), wide_t'(p5), N, oy));
    nz   = N'(sat_add(wide_t'(z), wide_t'(prod), N, oz));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      phase <= PH_SIGMA;
      remain <= '0;
      {x, y, z} <= '0;
      {sig_r, bet_r, rho_r, dt_r} <= '0;
      {p0, p1, p2, p3, p4, p5} <= '0;
      {valid, done, busy, sat} <= '0;
    end else if (en) begin
      valid <= 1'b0;
      done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            x <= icx;  y <= icy;  z <= icz;
            sig_r <= sigma;  bet_r <= beta;  rho_r <= rho;  dt_r <= dt;
            remain <= steps;
            sat    <= 1'b0;
            phase  <= PH_SIGMA;
            if (steps == '0) begin
              done <= 1'b1;
            end else begin
              busy  <= 1'b1;
              state <= S_RUN;
            end
          end
        end
        default: begin
          sat <= sat | mul_ovf | (sub_used & sub_ovf)
                     | ((phase == PH_COMMIT) & (ox | oy | oz));
          phase <= phase + 3'd1;
          case (phase)
            PH_SIGMA: p0 <= prod;
            PH_XRZ:   p1 <= prod;
            PH_XY:    p2 <= prod;
            PH_BZ:    p3 <= prod;
            PH_DX:    p4 <= prod;
            PH_DY:    p5 <= prod;
            default: begin
              x <= nx;  y <= ny;  z <= nz;
              valid  <= 1'b1;
              remain <= remain - SW'(1);
              phase  <= PH_SIGMA;
              if (remain == SW'(1)) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= S_IDLE;
              end
            end
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dda_lorenz_seq.sv
// Scoreboard bench for dda_lorenz_seq: an independent Euler model queues the
// expected state per step; each rising valid pops and compares.
module tb_dda_lorenz_seq;

  typedef logic signed [63:0] w_t;
  typedef struct { longint x; longint y; longint z; } st_t;

  localparam longint MAXV = 64'sd8388607;
  localparam longint MINV = -64'sd8388608;
  localparam longint ONE  = 64'sd65536;

  logic clk = 1'b0;
  logic rst, en, start;
  logic [15:0] steps;
  logic [23:0] icx, icy, icz, sigma, beta, rho, dt;
  logic [23:0] x, y, z;
  logic valid, done, busy, sat;

  int total = 0;
  int bad   = 0;
  st_t expq[$];
  bit  msat;
  st_t last_st;

  always #5 clk = ~clk;

  dda_lorenz_seq dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .steps(steps),
    .icx(icx), .icy(icy), .icz(icz),
    .sigma(sigma), .beta(beta), .rho(rho), .dt(dt),
    .x(x), .y(y), .z(z), .valid(valid), .done(done), .busy(busy), .sat(sat)
  );

  task automatic chk(input string tag, input w_t act, input w_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic w_t sx(input logic [23:0] v);
    return w_t'($signed(v));
  endfunction

  function automatic longint cl(input longint v);
    if (v > MAXV) begin msat = 1; return MAXV; end
    if (v < MINV) begin msat = 1; return MINV; end
    return v;
  endfunction

  function automatic longint fm(input longint a, input longint b);
    return cl((a * b) >>> 16);
  endfunction

  // Reference Euler model; fills the scoreboard and returns the expected sat flag.
  function automatic bit model(input int n, input longint ix, iy, iz, s, r, b, d);
    longint cx, cy, cz, q0, q1, q2, q3, q4, q5, q6;
    st_t e;
    cx = ix; cy = iy; cz = iz; msat = 0;
    for (int k = 0; k < n; k++) begin
      q0 = fm(s, cl(cy - cx));
      q1 = fm(cx, cl(r - cz));
      q2 = fm(cx, cy);
      q3 = fm(b, cz);
      q4 = fm(d, q0);
      q5 = fm(d, cl(q1 - cy));
      q6 = fm(d, cl(q2 - q3));
      cx = cl(cx + q4); cy = cl(cy + q5); cz = cl(cz + q6);
      e.x = cx; e.y = cy; e.z = cz;
      expq.push_back(e);
    end
    return msat;
  endfunction

  task automatic run_case(input string nm, input int n, input longint ix, iy, iz, s, r, b, d,
                          input bit tog, input bit rep, output st_t fin);
    int edges = 0;
    int nval  = 0;
    bit pv = 0, got = 0, cur_en, esat;
    st_t e;
    expq.delete();
    esat = model(n, ix, iy, iz, s, r, b, d);
    fin.x = ix; fin.y = iy; fin.z = iz;
    @(negedge clk);
    steps = 16'(n); icx = 24'(ix); icy = 24'(iy); icz = 24'(iz);
    sigma = 24'(s); rho = 24'(r); beta = 24'(b); dt = 24'(d);
    start = 1; en = 1;
    @(negedge clk);
    start = 0;
    chk({nm, "_busy_e0"}, w_t'(busy), w_t'(n != 0));
    chk({nm, "_done_e0"}, w_t'(done), w_t'(n == 0));
    chk({nm, "_sat_clr"}, w_t'(sat), 0);
    if (n == 0) begin
      chk({nm, "_x"}, sx(x), ix);
      chk({nm, "_y"}, sx(y), iy);
      chk({nm, "_z"}, sx(z), iz);
      chk({nm, "_novalid"}, w_t'(valid), 0);
      @(negedge clk);
      chk({nm, "_done_1cyc"}, w_t'(done), 0);
      chk({nm, "_novalid2"}, w_t'(valid), 0);
      return;
    end
    for (int c = 0; c < 4000 && !got; c++) begin
      cur_en = tog ? (c % 2 == 1) : 1'b1;
      en = cur_en;
      if (rep && (c % 5 == 2)) begin start = 1; icx = 24'h000007; end
      else start = 0;
      @(negedge clk);
      if (cur_en) edges++;
      if (valid && !pv) begin
        nval++;
        if (expq.size() > 0) begin
          e = expq.pop_front();
          chk({nm, "_x"}, sx(x), e.x);
          chk({nm, "_y"}, sx(y), e.y);
          chk({nm, "_z"}, sx(z), e.z);
          fin.x = sx(x); fin.y = sx(y); fin.z = sx(z);
        end else chk({nm, "_extra_valid"}, 1, 0);
      end
      pv = valid;
      if (done) got = 1;
    end
    start = 0; en = 1;
    chk({nm, "_done_seen"}, w_t'(got), 1);
    chk({nm, "_valid_cnt"}, nval, n);
    chk({nm, "_valid_w_done"}, w_t'(valid), 1);
    chk({nm, "_busy_drop"}, w_t'(busy), 0);
    chk({nm, "_en_edges"}, edges, 7 * n);
    chk({nm, "_sat"}, w_t'(sat), w_t'(esat));
    chk({nm, "_q_empty"}, expq.size(), 0);
    @(negedge clk);
    chk({nm, "_valid_1cyc"}, w_t'(valid), 0);
    chk({nm, "_done_1cyc"}, w_t'(done), 0);
  endtask

  initial begin
    st_t f1, f2;
    rst = 1; en = 0; start = 0; steps = 0;
    {icx, icy, icz, sigma, beta, rho, dt} = '0;
    @(negedge clk);
    chk("rst_x", sx(x), 0);
    chk("rst_busy", w_t'(busy), 0);
    chk("rst_flags", w_t'({valid, done, sat}), 0);
    rst = 0;

    // mid-run asynchronous reset
    @(negedge clk);
    steps = 5; icx = 24'h010000; icy = 24'h020000; icz = 24'h030000;
    sigma = 24'h0A0000; rho = 24'h1C0000; beta = 24'h02AAAA; dt = 24'h000100;
    start = 1; en = 1;
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    chk("mid_busy", w_t'(busy), 1);
    chk("mid_x_ic", sx(x), ONE);
    #2 rst = 1;
    #1;
    chk("arst_x", sx(x), 0);
    chk("arst_yz", w_t'({y, z}), 0);
    chk("arst_busy", w_t'(busy), 0);
    chk("arst_flags", w_t'({valid, done, sat}), 0);
    @(negedge clk);
    rst = 0;

    run_case("two", 2, ONE, 2 * ONE, 3 * ONE, 10 * ONE, 28 * ONE, 64'h02AAAA, 64'h100, 0, 0, f1);
    run_case("zero", 0, ONE, 2 * ONE, 3 * ONE, 0, 0, 0, ONE, 0, 0, f1);
    run_case("one", 1, ONE, 2 * ONE, 3 * ONE, 0, 0, 0, ONE, 0, 0, f1);
    chk("one_x", sx(x), 64'sh010000);
    chk("one_y", sx(y), -64'sd196608);
    chk("one_z", sx(z), 64'sh050000);
    run_case("satur", 1, 100 * ONE, 100 * ONE, 0, 0, 0, 0, ONE, 0, 0, f1);
    chk("satur_z", sx(z), 64'sh7FFFFF);
    chk("satur_flag", w_t'(sat), 1);
    run_case("satclr", 1, ONE, 2 * ONE, 3 * ONE, 0, 0, 0, ONE, 0, 0, f1);

    run_case("stall", 3, ONE, ONE, ONE, 10 * ONE, 28 * ONE, 64'h02AAAA, 64'h100, 1, 1, f1);
    run_case("nostall", 3, ONE, ONE, ONE, 10 * ONE, 28 * ONE, 64'h02AAAA, 64'h100, 0, 0, f2);
    chk("stall_eq_x", f1.x, f2.x);
    chk("stall_eq_z", f1.z, f2.z);

    run_case("golden", 100, ONE, ONE, ONE, 10 * ONE, 28 * ONE, 64'h02AAAA, 64'h100, 0, 0, last_st);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dda_lorenz_seq.md
# dda_lorenz_seq

Parametrised, time-multiplexed fixed-point DDA integrator for the Lorenz system; the successor of the fixed-width `dda` block. It adds several things `dda` lacks: a configurable word/fraction width, a start/busy/valid/done handshake, a programmable step count, saturating arithmetic with a sticky flag, and a single shared multiplier sequenced by an FSM. It sits between the parameter/IC register file and the output streaming logic.

## Interface
- `N`, 24, word width; signed two's-complement Q(N-FRAC).FRAC
- `FRAC`, 16, fraction bits (1.0 = 2^FRAC)
- `SW`, 16, step-counter width
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `en` in 1: clock enable. When low, all state holds and no pulses are generated.
- `start` in 1: request integration. Sampled only in IDLE with `en`=1.
- `steps` in SW: number of Euler steps, latched at start.
- `icx`, `icy`, `icz` in N: initial conditions, loaded at start.
- `sigma`, `beta`, `rho`, `dt` in N: coefficients, latched at start.
- `x`, `y`, `z` out N: current state, registered.
- `valid` out 1: one-cycle pulse when a step commits new x/y/z.
- `done` out 1: one-cycle pulse at completion.
- `busy` out 1: high while integrating.
- `sat` out 1: sticky; set when any saturation occurs, cleared by start.

## Operation
- Equations per step:
  - dx=σ(y−x)
  - dy=x(ρ−z)−y
  - dz=xy−βz
  - x+=dt·dx, y+=dt·dy, z+=dt·dz, all using old x/y/z.
- FSM states: IDLE and RUN (phase counter 0..6).
- IDLE with start accepted:
  - x/y/z←ic; coefficients and steps latched; sat←0.
  - If steps=0: done←1, stay IDLE.
  - Otherwise: busy←1, RUN at phase 0.
- RUN phases use one multiply per cycle into regs p0..p5:
  - 0: σ·(y−x)
  - 1: x·(ρ−z)
  - 2: x·y
  - 3: β·z
  - 4: dt·p0
  - 5: dt·(p1−y)
- RUN phase 6:
  - Multiply dt·(p2−p3).
  - Commit x←x+p4, y←y+p5, z←z+product; valid←1.
  - Decrement remaining count. If it reaches 0: done←1, busy←0, go IDLE. Else go to phase 0.
- Multiply: full 2N-bit signed product, arithmetic shift right by FRAC (truncate toward −∞), then saturate to N bits.
- Add/sub: computed at N+1 bits, then saturated to [−2^(N−1), 2^(N−1)−1]. Any clamp sets sat.
- start while busy is ignored. Coefficient inputs may change freely during RUN without effect.
- rst mid-run: immediate return to IDLE; all outputs 0.

## Timing
- Reset values: x=y=z=0; valid=done=busy=sat=0; FSM IDLE; phase 0.
- Start accepted at enabled edge E0. busy is visible after E0. The first commit is at E7, so valid is high in the cycle after E7.
- Step k commits at E(7k), so there is 7-cycle throughput per step. The final valid and done coincide, and busy drops in the same cycle.
- steps=0: done is high in the cycle after E0; valid stays 0.
- Edges with en=0 do not count; latency stretches accordingly.
- valid and done are registered pulses, exactly one enabled cycle wide.

## Structure
- Package `dda_pkg`:
  - Phase encoding constants (PH_SIGMA..PH_COMMIT).
  - FSM state enum.
  - Saturating add/sub functions parametrised by N.
- Sub-module `dda_fxmul` (parameters N, FRAC): combinational signed multiply, shift, and saturate, with an `ovf` output. It is instantiated once and fed by a phase-indexed operand mux.

## Test plan
- Reset: assert rst asynchronously mid-cycle → all outputs 0 immediately. Deassert, start with steps=2 → busy rises after first edge.
- Zero steps: ic=(1,2,3), i.e. 0x010000/0x020000/0x030000; steps=0 → done high one cycle after start, x/y/z = ic, valid never asserted.
- Single step: σ=ρ=β=0, dt=1.0, ic=(1,2,3), steps=1 → valid=done at cycle 7, x=1.0, y=−3.0 (0xFD0000), z=5.0, sat=0.
- Saturation: ic=(100,100,0), β=0, dt=1.0, steps=1 → z=0x7FFFFF, sat=1. Next start clears sat.
- en gating plus busy start: steps=3 with en toggled 50%, start re-pulsed while busy → start ignored, exactly 3 valid pulses, 21 enabled edges, results match the unstalled run.
- Golden Lorenz: σ=10, ρ=28, β=8/3 (0x02AAAA), dt=1/256, ic=(1,1,1), steps=100 → x/y/z bit-exact against the reference model at every valid.
